// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Signal bundle between the two requesters, the arbiter and the single-port
//   memory.
//   Parameters: DATA_W (data width), ADDR_W (word address width).
//   Requester channel N (N = 0, 1):
//     rN_valid, rN_WR, rN_addr, rN_data_in  : request, held until rN_ready
//     rN_ready, rN_data_out, rN_err         : one-cycle completion
//   Memory port:
//     mem_valid, mem_WR, mem_addr, mem_data_in : command to memory
//     mem_data_out, mem_ready                  : response from memory
//   Modports:
//     slave  : the arbiter's view
//     master : the environment's view (requesters plus memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              r0_valid;
    logic              r0_WR;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_data_in;
    logic              r0_ready;
    logic [DATA_W-1:0] r0_data_out;
    logic              r0_err;

    logic              r1_valid;
    logic              r1_WR;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_data_in;
    logic              r1_ready;
    logic [DATA_W-1:0] r1_data_out;
    logic              r1_err;

    logic              mem_valid;
    logic              mem_WR;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_ready;

    modport slave (
        input  r0_valid, r0_WR, r0_addr, r0_data_in,
        output r0_ready, r0_data_out, r0_err,
        input  r1_valid, r1_WR, r1_addr, r1_data_in,
        output r1_ready, r1_data_out, r1_err,
        output mem_valid, mem_WR, mem_addr, mem_data_in,
        input  mem_data_out, mem_ready
    );

    modport master (
        output r0_valid, r0_WR, r0_addr, r0_data_in,
        input  r0_ready, r0_data_out, r0_err,
        output r1_valid, r1_WR, r1_addr, r1_data_in,
        input  r1_ready, r1_data_out, r1_err,
        input  mem_valid, mem_WR, mem_addr, mem_data_in,
        output mem_data_out, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester round-robin arbiter and sequencer in front of a single-port
//   memory. A granted request is latched into the mem_* registers and held
//   until the memory answers with mem_ready; the winner then gets a one-cycle
//   rN_ready pulse with the read data (0 for writes).
//
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-high
//     bus   : mem_arbiter_if.slave (requester channels r0/r1, memory port)
//   Parameters:
//     DATA_W  : data width (16)
//     ADDR_W  : word address width (10)
//     TIMEOUT : BUSY cycles before abort, 2..255 (timeout build only)
//
//   Build option:
//     MEM_ARB_TIMEOUT_EN : when defined, a transaction still waiting after
//       TIMEOUT BUSY cycles is aborted and completes with rN_err=1 and
//       rN_data_out=0. When undefined, BUSY waits indefinitely and rN_err is 0.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_arbiter: TIMEOUT must lie in 2..255");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic              last;       // requester granted most recently
    logic              gnt;        // owner of the in-flight transaction
    logic              mem_valid_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              rdy_q  [2];
    logic [DATA_W-1:0] dout_q [2];

    // Round-robin choice; only meaningful when at least one valid is set.
    function automatic logic pick_gnt(input logic v0, input logic v1,
                                      input logic last_gnt);
        if (v0 && v1)
            return ~last_gnt;
        return v1 & ~v0;
    endfunction

    logic              nxt_gnt;
    logic              nxt_wr;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_data;
    logic [DATA_W-1:0] rsp_data;

    assign nxt_gnt  = pick_gnt(bus.r0_valid, bus.r1_valid, last);
    assign nxt_wr   = nxt_gnt ? bus.r1_WR      : bus.r0_WR;
    assign nxt_addr = nxt_gnt ? bus.r1_addr    : bus.r0_addr;
    assign nxt_data = nxt_gnt ? bus.r1_data_in : bus.r0_data_in;
    // Writes return zero rather than whatever the memory drives.
    assign rsp_data = mem_wr_q ? '0 : bus.mem_data_out;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tcnt;
    logic       err_q [2];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            gnt         <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                rdy_q[i]  <= 1'b0;
                dout_q[i] <= '0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            tcnt <= '0;
            for (int i = 0; i < 2; i++)
                err_q[i] <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.r0_valid || bus.r1_valid) begin
                        gnt         <= nxt_gnt;
                        last        <= nxt_gnt;
                        mem_valid_q <= 1'b1;
                        mem_wr_q    <= nxt_wr;
                        mem_addr_q  <= nxt_addr;
                        mem_din_q   <= nxt_data;
                        state       <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        tcnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    // mem_ready in the limit cycle still counts as success.
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        rdy_q[gnt]  <= 1'b1;
                        dout_q[gnt] <= rsp_data;
                        state       <= DONE;
`ifdef MEM_ARB_TIMEOUT_EN
                        err_q[gnt]  <= 1'b0;
                    end else if (tcnt == TCNT_LAST) begin
                        mem_valid_q <= 1'b0;
                        rdy_q[gnt]  <= 1'b1;
                        dout_q[gnt] <= '0;
                        err_q[gnt]  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
`endif
                    end
                end
                DONE: begin
                    rdy_q[gnt] <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_q[gnt] <= 1'b0;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_WR      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_din_q;
    assign bus.r0_ready    = rdy_q[0];
    assign bus.r1_ready    = rdy_q[1];
    assign bus.r0_data_out = dout_q[0];
    assign bus.r1_data_out = dout_q[1];
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.r0_err      = err_q[0];
    assign bus.r1_err      = err_q[1];
`else
    assign bus.r0_err      = 1'b0;
    assign bus.r1_err      = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Bench for mem_arbiter: a memory responder, a transaction-level reference
//   model checked against every output each cycle, and directed scenarios
//   with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int DW  = 16;
    localparam int AW  = 10;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Requester drive
    logic          rv    [2];
    logic          rwr   [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rdin  [2];

    assign bus.r0_valid   = rv[0];
    assign bus.r0_WR      = rwr[0];
    assign bus.r0_addr    = raddr[0];
    assign bus.r0_data_in = rdin[0];
    assign bus.r1_valid   = rv[1];
    assign bus.r1_WR      = rwr[1];
    assign bus.r1_addr    = raddr[1];
    assign bus.r1_data_in = rdin[1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a * 37 + 16'h1234);
    endfunction

    // Memory responder: acks after ack_delay extra cycles of mem_valid
    logic [DW-1:0] bmem [1024];
    logic          bfm_rdy  = 1'b0;
    logic          spur     = 1'b0;
    logic          stuck    = 1'b0;
    logic [DW-1:0] bfm_dout = 16'hDEAD;
    int            ack_delay = 0;
    int            wait_cnt  = 0;

    assign bus.mem_ready    = bfm_rdy | spur;
    assign bus.mem_data_out = bfm_dout;

    always @(posedge clk) begin
        #1;
        if (bus.mem_valid && !bfm_rdy && !stuck && wait_cnt >= ack_delay) begin
            bfm_rdy  = 1'b1;
            bfm_dout = bus.mem_WR ? 16'hBEEF : bmem[bus.mem_addr];
            if (bus.mem_WR)
                bmem[bus.mem_addr] = bus.mem_data_in;
        end else begin
            if (bus.mem_valid && !bfm_rdy) wait_cnt++;
            else                           wait_cnt = 0;
            bfm_rdy  = 1'b0;
            bfm_dout = 16'hDEAD;
        end
    end

    // Reference model: one transaction at a time, one completion cycle,
    // one idle cycle in which new requests are arbitrated.
    int            m_serv  = -1;   // requester on the memory bus, -1 none
    int            m_rep   = -1;   // requester being told of completion
    int            m_last  = 1;
    int            m_nbusy = 0;
    int            m_w;
    bit            m_live  = 0;
    logic          e_mv    = 1'b0;
    logic          e_mwr   = 1'b0;
    logic [AW-1:0] e_maddr = '0;
    logic [DW-1:0] e_mdin  = '0;
    logic          e_rdy   [2];
    logic [DW-1:0] e_dout  [2];
    logic          e_err   [2];
    logic [DW-1:0] ref_mem [1024];

    task automatic m_finish(input bit abort);
        e_mv           = 1'b0;
        e_rdy[m_serv]  = 1'b1;
        e_err[m_serv]  = abort;
        e_dout[m_serv] = (abort || e_mwr) ? '0 : ref_mem[e_maddr];
        if (!abort && e_mwr)
            ref_mem[e_maddr] = e_mdin;
        m_rep  = m_serv;
        m_serv = -1;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1; m_serv = -1; m_rep = -1; m_last = 1; m_nbusy = 0;
            e_mv = 1'b0; e_mwr = 1'b0; e_maddr = '0; e_mdin = '0;
            for (int i = 0; i < 2; i++) begin
                e_rdy[i] = 1'b0; e_dout[i] = '0; e_err[i] = 1'b0;
            end
        end else if (m_live) begin
            if (m_rep >= 0) begin
                e_rdy[m_rep] = 1'b0;
                e_err[m_rep] = 1'b0;
                m_rep = -1;
            end else if (m_serv >= 0) begin
                m_nbusy++;
                if (bus.mem_ready) m_finish(1'b0);
`ifdef MEM_ARB_TIMEOUT_EN
                else if (m_nbusy == TMO) m_finish(1'b1);
`endif
            end else begin
                m_w = -1;
                if (rv[0] && rv[1]) m_w = 1 - m_last;
                else if (rv[0])     m_w = 0;
                else if (rv[1])     m_w = 1;
                if (m_w >= 0) begin
                    m_serv = m_w; m_last = m_w; m_nbusy = 0;
                    e_mv = 1'b1; e_mwr = rwr[m_w]; e_maddr = raddr[m_w]; e_mdin = rdin[m_w];
                end
            end
        end
    end

    // Per-cycle compare plus simple monitors used by the directed checks
    int            mv_cnt = 0;
    logic [AW-1:0] mon_addr;
    logic [DW-1:0] mon_din;
    int            pulses [2];
    int            order  [$];

    always @(negedge clk) begin
        if (m_live) begin
            chk("mem_valid",   32'(bus.mem_valid),   32'(e_mv));
            chk("mem_WR",      32'(bus.mem_WR),      32'(e_mwr));
            chk("mem_addr",    32'(bus.mem_addr),    32'(e_maddr));
            chk("mem_data_in", 32'(bus.mem_data_in), 32'(e_mdin));
            chk("r0_ready",    32'(bus.r0_ready),    32'(e_rdy[0]));
            chk("r1_ready",    32'(bus.r1_ready),    32'(e_rdy[1]));
            chk("r0_data_out", 32'(bus.r0_data_out), 32'(e_dout[0]));
            chk("r1_data_out", 32'(bus.r1_data_out), 32'(e_dout[1]));
            chk("r0_err",      32'(bus.r0_err),      32'(e_err[0]));
            chk("r1_err",      32'(bus.r1_err),      32'(e_err[1]));
            if (bus.mem_valid) begin
                mv_cnt++;
                mon_addr = bus.mem_addr;
                mon_din  = bus.mem_data_in;
            end
            if (bus.r0_ready) begin pulses[0]++; order.push_back(0); end
            if (bus.r1_ready) begin pulses[1]++; order.push_back(1); end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        mv_cnt = 0; pulses[0] = 0; pulses[1] = 0; order.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; rv[0] = 1'b0; rv[1] = 1'b0;
        sync(); sync();
        reset = 1'b0;
    endtask

    // Present a request at the current point (posedge+1), wait for ready,
    // then drop valid in the following cycle.
    task automatic req(input int id, input logic wr, input int addr, input logic [DW-1:0] data,
                       output logic [DW-1:0] dout, output logic err, output int lat);
        bit got = 0;
        rv[id] = 1'b1; rwr[id] = wr; raddr[id] = AW'(addr); rdin[id] = data;
        lat = 0; dout = '0; err = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            lat++;
            if ((id == 0) ? bus.r0_ready : bus.r1_ready) begin
                got  = 1;
                dout = (id == 0) ? bus.r0_data_out : bus.r1_data_out;
                err  = (id == 0) ? bus.r0_err : bus.r1_err;
            end
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL req%0d_wait: no ready within %0d cycles, required a pulse", id, lat);
        end
        sync();
        rv[id] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d0, d1;
        logic          e0, e1;
        int            l0, l1;

        for (int a = 0; a < 1024; a++) begin
            bmem[a]    = init_word(a);
            ref_mem[a] = init_word(a);
        end
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rwr[i] = 1'b0; raddr[i] = '0; rdin[i] = '0;
        end

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_r0_ready",  32'(bus.r0_ready),  32'd0);
        chk("rst_r1_dout",   32'(bus.r1_data_out), 32'd0);
        sync();

        // Single write from r0, immediate memory ack
        clear_mon();
        req(0, 1'b1, 5, 16'h3524, d0, e0, l0);
        chk("wr_latency",   32'(l0), 32'd3);
        chk("wr_err",       32'(e0), 32'd0);
        chk("wr_dout",      32'(d0), 32'd0);
        chk("wr_mv_cycles", 32'(mv_cnt), 32'd1);
        chk("wr_mem_addr",  32'(mon_addr), 32'd5);
        chk("wr_mem_data",  32'(mon_din), 32'h3524);
        chk("wr_r0_pulses", 32'(pulses[0]), 32'd1);
        chk("wr_r1_pulses", 32'(pulses[1]), 32'd0);

        // Read back from r1, presented in the idle cycle right after
        req(1, 1'b0, 5, 16'h0000, d1, e1, l1);
        chk("rd_data",    32'(d1), 32'h3524);
        chk("rd_latency", 32'(l1), 32'd3);
        chk("rd_err",     32'(e1), 32'd0);

        // Simultaneous writes right after reset: r0 first
        do_reset();
        sync();
        clear_mon();
        fork
            req(0, 1'b1, 35, 16'hA035, d0, e0, l0);
            req(1, 1'b1, 25, 16'h5025, d1, e1, l1);
        join
        chk("sim_count",  32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("sim_first",  32'(order[0]), 32'd0);
            chk("sim_second", 32'(order[1]), 32'd1);
        end
        req(0, 1'b0, 35, 16'h0000, d0, e0, l0);
        chk("rb35", 32'(d0), 32'hA035);
        req(1, 1'b0, 25, 16'h0000, d1, e1, l1);
        chk("rb25", 32'(d1), 32'h5025);

        // Continuous contention, memory acks one cycle late
        do_reset();
        sync();
        ack_delay = 1;
        clear_mon();
        fork
            begin
                logic [DW-1:0] dd; logic ee; int ll;
                for (int i = 0; i < 3; i++) req(0, 1'b1, 100 + i, DW'(16'h0C00 + i), dd, ee, ll);
            end
            begin
                logic [DW-1:0] dd; logic ee; int ll;
                for (int i = 0; i < 3; i++) req(1, 1'b0, 200 + i, 16'h0000, dd, ee, ll);
            end
        join
        chk("rr_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < order.size() && i < 6; i++)
            chk($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
        ack_delay = 0;

        // mem_ready while idle is ignored
        sync();
        clear_mon();
        spur = 1'b1;
        sync(); sync();
        spur = 1'b0;
        sync();
        chk("spur_pulses", 32'(pulses[0] + pulses[1]), 32'd0);
        chk("spur_mv",     32'(mv_cnt), 32'd0);

        // Memory never answers
        clear_mon();
        stuck = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        req(0, 1'b0, 9, 16'h0000, d0, e0, l0);
        chk("tmo_err",     32'(e0), 32'd1);
        chk("tmo_dout",    32'(d0), 32'd0);
        chk("tmo_busy",    32'(mv_cnt), 32'd16);
        chk("tmo_latency", 32'(l0), 32'd18);
`else
        rv[0] = 1'b1; rwr[0] = 1'b0; raddr[0] = AW'(9);
        repeat (40) @(negedge clk);
        chk("stuck_pulses", 32'(pulses[0]), 32'd0);
        chk("stuck_err",    32'(bus.r0_err), 32'd0);
        chk("stuck_mv",     32'(bus.mem_valid), 32'd1);
        sync();
`endif

        // Reset while BUSY, then a fresh read completes normally
        clear_mon();
        rv[0] = 1'b1; rwr[0] = 1'b0; raddr[0] = AW'(9);
        repeat (4) @(negedge clk);
        chk("pre_rst_mv", 32'(bus.mem_valid), 32'd1);
        sync();
        reset = 1'b1; rv[0] = 1'b0;
        sync();
        reset = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        chk("mid_rst_mv",  32'(bus.mem_valid), 32'd0);
        chk("mid_rst_r0",  32'(bus.r0_ready), 32'd0);
        chk("mid_rst_r1",  32'(bus.r1_ready), 32'd0);
        chk("mid_rst_err", 32'(bus.r0_err), 32'd0);
        sync();
        req(1, 1'b0, 51, 16'h0000, d1, e1, l1);
        chk("post_rst_data",    32'(d1), 32'(init_word(51)));
        chk("post_rst_err",     32'(e1), 32'd0);
        chk("post_rst_latency", 32'(l1), 32'd3);
        chk("post_rst_r0",      32'(pulses[0]), 32'd0);

        sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
